// File: rtl/l1_mem_responder.sv
// Memory-side responder for the L1 request/return protocol: byte-masked writes, aligned burst reads, DMA port.
// Define L1_MEM_RESPONDER_INV_EN to queue DMA write addresses as cache invalidations.
module l1_mem_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_request,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_rnw,
  input  logic [3:0]  req_be,
  input  logic [4:0]  req_size,
  input  logic        req_is_amo,
  input  logic [4:0]  req_amo,
  output logic        req_ack,
  output logic        rsp_data_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_inv_valid,
  output logic [29:0] rsp_inv_addr,
  input  logic        rsp_inv_ack,
  input  logic        dma_we,
  input  logic [29:0] dma_addr,
  input  logic [31:0] dma_data,
  output logic        error,
  output logic [1:0]  dbg_state
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam logic [5:0] MAX_LEN = 6'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_t;

  state_t        state;
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] ptr;
  logic [LW-1:0] remain;
  logic [2:0]    wait_cnt;

  logic [AW-1:0] req_word;
  logic [AW-1:0] req_base;
  logic [AW-1:0] dma_word;
  logic [5:0]    req_len_raw;
  logic [5:0]    req_len;
  logic          size_over;
  logic          size_bad;
  logic          rd_accept;
  logic          wr_accept;
  logic          drop_inv;

  // Handshake: a request transfers in a cycle with req_request & req_ack; the requester
  // holds all req_* fields stable until then. DMA writes are always taken, never stalled.
  assign req_ack   = req_request && (state == S_IDLE) && !dma_we;
  assign rd_accept = req_ack && req_rnw;
  assign wr_accept = req_ack && !req_rnw;
  assign dbg_state = state;

  assign req_word    = req_addr[AW+1:2];
  assign req_base    = req_word & ~AW'(req_size);
  assign dma_word    = dma_addr[AW-1:0];
  assign req_len_raw = {1'b0, req_size} + 6'd1;
  assign size_over   = req_len_raw > MAX_LEN;
  assign size_bad    = size_over || ((req_len_raw & (req_len_raw - 6'd1)) != 6'd0);
  assign req_len     = size_over ? MAX_LEN : req_len_raw;

  always_ff @(posedge clk) begin
    if (dma_we) begin
      mem[dma_word] <= dma_data;
    end else if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[req_word][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  // Read word is bypassed from a same-cycle DMA write so a beat always shows the newest data.
  always_comb begin
    rsp_data = '0;
    if (rsp_data_valid) rsp_data = (dma_we && (dma_word == ptr)) ? dma_data : mem[ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      rsp_data_valid <= 1'b0;
      ptr            <= '0;
      remain         <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_accept) begin
            ptr    <= req_base;
            remain <= LW'(req_len - 6'd1);
            if (READ_LATENCY == 1) begin
              state          <= S_BURST;
              rsp_data_valid <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 3'(READ_LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state          <= S_BURST;
            rsp_data_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_BURST: begin
          if (remain == '0) begin
            state          <= S_IDLE;
            rsp_data_valid <= 1'b0;
          end else begin
            ptr    <= ptr + 1'b1;
            remain <= remain - 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          rsp_data_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error <= 1'b0;
    else if ((rd_accept && size_bad) || (req_ack && req_is_amo) || drop_inv) error <= 1'b1;
  end

`ifdef L1_MEM_RESPONDER_INV_EN
  logic [29:0] inv_fifo [4];
  logic [1:0]  inv_wr;
  logic [1:0]  inv_rd;
  logic [2:0]  inv_cnt;
  logic        inv_push;
  logic        inv_pop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
  assign inv_pop       = (inv_cnt != 3'd0) && rsp_inv_ack;
  assign inv_push      = dma_we && ((inv_cnt != 3'd4) || inv_pop);
  assign drop_inv      = dma_we && !inv_push;
  assign rsp_inv_valid = inv_cnt != 3'd0;
  assign rsp_inv_addr  = inv_fifo[inv_rd];

  always_ff @(posedge clk) begin
    if (inv_push) inv_fifo[inv_wr] <= dma_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_wr  <= '0;
      inv_rd  <= '0;
      inv_cnt <= '0;
    end else begin
      if (inv_push) inv_wr <= inv_wr + 2'd1;
      if (inv_pop)  inv_rd <= inv_rd + 2'd1;
      case ({inv_push, inv_pop})
        2'b10:   inv_cnt <= inv_cnt + 3'd1;
        2'b01:   inv_cnt <= inv_cnt - 3'd1;
        default: inv_cnt <= inv_cnt;
      endcase
    end
  end

  logic unused_inv;
  assign unused_inv = 1'b0;
`else
  assign rsp_inv_valid = 1'b0;
  assign rsp_inv_addr  = '0;
  assign drop_inv      = 1'b0;

  logic unused_inv;
  assign unused_inv = rsp_inv_ack;
`endif

  // AMO opcodes are accepted but executed as plain accesses; high address bits alias.
  logic unused_req;
  assign unused_req = ^{req_amo, req_addr[1:0], req_addr[31:AW+2], dma_addr[29:AW]};

endmodule

// File: tb/tb_l1_mem_responder.sv
// Bench for l1_mem_responder: vector table, hand-written corner sequences and randomized
// reads/writes/DMA checked against a word-array reference model.
`timescale 1ns/1ps
module tb_l1_mem_responder;
  localparam int MEM_WORDS    = 4096;
  localparam int READ_LATENCY = 2;
  localparam int MAX_BURST    = 16;
  localparam int AW           = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_request;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_rnw;
  logic [3:0]  req_be;
  logic [4:0]  req_size;
  logic        req_is_amo;
  logic [4:0]  req_amo;
  logic        req_ack;
  logic        rsp_data_valid;
  logic [31:0] rsp_data;
  logic        rsp_inv_valid;
  logic [29:0] rsp_inv_addr;
  logic        rsp_inv_ack;
  logic        dma_we;
  logic [29:0] dma_addr;
  logic [31:0] dma_data;
  logic        error;
  logic [1:0]  dbg_state;

  l1_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(READ_LATENCY), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_request(req_request), .req_addr(req_addr), .req_data(req_data), .req_rnw(req_rnw),
    .req_be(req_be), .req_size(req_size), .req_is_amo(req_is_amo), .req_amo(req_amo),
    .req_ack(req_ack), .rsp_data_valid(rsp_data_valid), .rsp_data(rsp_data),
    .rsp_inv_valid(rsp_inv_valid), .rsp_inv_addr(rsp_inv_addr), .rsp_inv_ack(rsp_inv_ack),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_data(dma_data),
    .error(error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]   model_mem [MEM_WORDS];
  bit            model_err;
  logic [AW-1:0] exp_q[$];
  logic [31:0]   got_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  size;
    bit          amo;
    logic [31:0] exp_first;
    int          exp_len;
    bit          exp_err;
  } rd_vec_t;

  rd_vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_request = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    req_rnw     = 1'b1;
    req_be      = '0;
    req_size    = '0;
    req_is_amo  = 1'b0;
    req_amo     = '0;
    dma_we      = 1'b0;
    dma_addr    = '0;
    dma_data    = '0;
  endtask

  task automatic dma_set(input int word, input logic [31:0] data);
    dma_we   = 1'b1;
    dma_addr = 30'(word);
    dma_data = data;
    model_mem[word & (MEM_WORDS - 1)] = data;
  endtask

  task automatic do_reset();
    next_cycle();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack", req_ack, 0);
    check("rst_valid", rsp_data_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_inv_valid", rsp_inv_valid, 0);
    check("rst_error", error, 0);
    next_cycle();
    rst = 1'b0;
    model_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                          input bit amo, input string tag);
    int waited;
    int w;
    waited = 0;
    next_cycle();
    dma_we      = 1'b0;
    req_request = 1'b1;
    req_rnw     = 1'b0;
    req_addr    = addr;
    req_data    = data;
    req_be      = be;
    req_is_amo  = amo;
    req_amo     = amo ? 5'($urandom_range(0, 31)) : 5'd0;
    req_size    = 5'($urandom_range(0, 31));
    @(negedge clk);
    while (!req_ack && waited < 20) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    check({tag, "_ack_wait"}, 32'(waited), 0);
    w = int'((addr >> 2) & (MEM_WORDS - 1));
    for (int b = 0; b < 4; b++) if (be[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
    if (amo) model_err = 1'b1;
    next_cycle();
    req_request = 1'b0;
    req_is_amo  = 1'b0;
    @(negedge clk);
    check({tag, "_no_valid"}, rsp_data_valid, 0);
    check({tag, "_err"}, error, model_err);
  endtask

  // One read transaction; beats are checked cycle by cycle against the model array.
  task automatic do_read(input logic [31:0] addr, input logic [4:0] size, input bit amo,
                         input bit dma_first, input bit rand_dma, input int inj_cycle,
                         input int inj_off, input logic [31:0] inj_data, input bit b2b,
                         input string tag);
    int sz, len, base, waited, last, w;
    logic [AW-1:0] a;
    sz   = int'(size) + 1;
    len  = (sz > MAX_BURST) ? MAX_BURST : sz;
    base = int'((addr >> 2) & (MEM_WORDS - 1)) & ~int'(size);
    last = READ_LATENCY + len;
    if (sz > MAX_BURST || (sz & (sz - 1)) != 0 || amo) model_err = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(AW'(base + k));

    next_cycle();
    req_request = 1'b1;
    req_rnw     = 1'b1;
    req_addr    = addr;
    req_size    = size;
    req_is_amo  = amo;
    req_amo     = 5'($urandom_range(0, 31));
    req_be      = 4'($urandom_range(0, 15));
    req_data    = $urandom;
    if (dma_first) dma_set($urandom_range(0, MEM_WORDS - 1), $urandom);
    else dma_we = 1'b0;
    @(negedge clk);
    if (dma_first) begin
      check({tag, "_dma_blocks_ack"}, req_ack, 0);
      next_cycle();
      dma_we = 1'b0;
      @(negedge clk);
    end
    waited = 0;
    while (!req_ack && waited < 20) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    check({tag, "_ack_wait"}, 32'(waited), 0);

    for (int c = 1; c <= last; c++) begin
      next_cycle();
      req_request = 1'b0;
      req_is_amo  = 1'b0;
      dma_we      = 1'b0;
      if (c == last && b2b) begin
        req_request = 1'b1;
        req_rnw     = 1'b0;
        req_addr    = $urandom;
        req_data    = $urandom;
        req_be      = 4'hF;
      end else if (c == inj_cycle) begin
        dma_set(base + inj_off, inj_data);
      end else if (rand_dma && c < last && $urandom_range(0, 2) == 0) begin
        dma_set(base + $urandom_range(0, len - 1), $urandom);
      end
      @(negedge clk);
      if (c >= READ_LATENCY && c < last) begin
        check({tag, "_valid"}, rsp_data_valid, 1);
        a = exp_q.pop_front();
        got_q.push_back(rsp_data);
        check({tag, "_data"}, rsp_data, model_mem[a]);
      end else begin
        check({tag, "_idle_valid"}, rsp_data_valid, 0);
      end
      if (c == last && b2b) begin
        check({tag, "_b2b_ack"}, req_ack, 1);
        w = int'((req_addr >> 2) & (MEM_WORDS - 1));
        model_mem[w] = req_data;
      end
    end
    if (b2b) begin
      next_cycle();
      req_request = 1'b0;
    end
    check({tag, "_err"}, error, model_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [29:0] inv_addrs[5];
    int sz_pick;
    rst = 1'b1;
    rsp_inv_ack = 1'b1;
    drive_idle();

    vecs[0] = '{32'h0000_0094, 5'd3,  1'b0, 32'h024, 4,  1'b0};
    vecs[1] = '{32'h0000_3FF0, 5'd7,  1'b0, 32'hFF8, 8,  1'b0};
    vecs[2] = '{32'h0000_4000, 5'd0,  1'b0, 32'h000, 1,  1'b0};
    vecs[3] = '{32'h0000_0108, 5'd2,  1'b0, 32'h040, 3,  1'b1};
    vecs[4] = '{32'h0000_0200, 5'd31, 1'b0, 32'h080, 16, 1'b1};
    vecs[5] = '{32'h0000_007C, 5'd15, 1'b0, 32'h010, 16, 1'b0};
    vecs[6] = '{32'h0000_0020, 5'd1,  1'b1, 32'h008, 2,  1'b1};
    vecs[7] = '{32'h0000_3FFC, 5'd4,  1'b0, 32'hFFB, 5,  1'b1};
    vecs[8] = '{32'hFFFF_FFFC, 5'd1,  1'b0, 32'hFFE, 2,  1'b0};

    do_reset();

    // RAM[i] = i through the DMA port
    for (int i = 0; i < MEM_WORDS; i++) begin
      next_cycle();
      dma_set(i, 32'(i));
    end
    next_cycle();
    dma_we = 1'b0;
    do_reset();

    // vector table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      do_read(vecs[i].addr, vecs[i].size, vecs[i].amo, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, "vec");
      check($sformatf("vec%0d_first", i), (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX,
            vecs[i].exp_first);
      check($sformatf("vec%0d_len", i), 32'(got_q.size()), 32'(vecs[i].exp_len));
      check($sformatf("vec%0d_err", i), error, 32'(vecs[i].exp_err));
    end

    // byte-masked write over preloaded word, then single-word read
    do_reset();
    next_cycle();
    dma_set(32'h10, 32'h1122_3344);
    do_write(32'h40, 32'hAABB_CCDD, 4'b0101, 1'b0, "wr_be");
    do_read(32'h40, 5'd0, 1'b0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, "rd_be");
    check("rd_be_word", (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX, 32'h11BB_33DD);

    // DMA blocks ack for one cycle; DMA in WAIT to base+3 lands in the 4th beat
    do_read(32'h94, 5'd3, 1'b0, 1'b1, 1'b0, 1, 3, 32'h0000_DEAD, 1'b0, "dma_mid");
    check("dma_mid_word3", (got_q.size() > 3) ? got_q[3] : 32'hXXXX_XXXX, 32'h0000_DEAD);

    // DMA to the word being returned in that same cycle
    do_read(32'h300, 5'd1, 1'b0, 1'b0, 1'b0, READ_LATENCY, 0, 32'hCAFE_F00D, 1'b1, "raw");
    check("raw_word0", (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX, 32'hCAFE_F00D);

    // AMO write flags error but still updates RAM
    do_reset();
    do_write(32'h180, 32'h5A5A_1234, 4'hF, 1'b1, "amo_wr");
    check("amo_wr_error", error, 1);
    do_read(32'h180, 5'd0, 1'b0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, "amo_rd");
    check("amo_rd_word", (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX, 32'h5A5A_1234);

    // reset in the middle of a burst drops data_valid without a clock edge
    do_reset();
    next_cycle();
    req_request = 1'b1;
    req_rnw     = 1'b1;
    req_addr    = 32'h100;
    req_size    = 5'd7;
    @(negedge clk);
    check("mid_rst_ack", req_ack, 1);
    for (int c = 1; c <= READ_LATENCY + 1; c++) begin
      next_cycle();
      req_request = 1'b0;
    end
    @(negedge clk);
    check("mid_rst_valid_before", rsp_data_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid_after", rsp_data_valid, 0);
    check("mid_rst_data_after", rsp_data, 0);
    next_cycle();
    rst = 1'b0;
    model_err = 1'b0;
    do_read(32'h44, 5'd1, 1'b0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, "post_rst");

`ifdef L1_MEM_RESPONDER_INV_EN
    // five DMA writes against a stalled invalidation consumer
    do_reset();
    inv_addrs[0] = 30'h0000_0123;
    inv_addrs[1] = 30'h3FFF_F001;
    inv_addrs[2] = 30'h0000_0456;
    inv_addrs[3] = 30'h0000_0789;
    inv_addrs[4] = 30'h0000_0ABC;
    next_cycle();
    rsp_inv_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      dma_set(int'(inv_addrs[i]), $urandom);
    end
    next_cycle();
    dma_we = 1'b0;
    model_err = 1'b1;
    @(negedge clk);
    check("inv_valid_full", rsp_inv_valid, 1);
    check("inv_head", 32'(rsp_inv_addr), 32'(inv_addrs[0]));
    check("inv_drop_error", error, 1);
    next_cycle();
    rsp_inv_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("inv_pop%0d_valid", i), rsp_inv_valid, 1);
      check($sformatf("inv_pop%0d_addr", i), 32'(rsp_inv_addr), 32'(inv_addrs[i]));
      next_cycle();
    end
    @(negedge clk);
    check("inv_empty", rsp_inv_valid, 0);
    do_read(32'(inv_addrs[4]) << 2, 5'd0, 1'b0, 1'b0, 1'b0, -1, 0, 32'h0, 1'b0, "inv_dropped_rd");
    do_reset();
`else
    // without invalidations, DMA writes never raise inv_valid or error
    do_reset();
    next_cycle();
    rsp_inv_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      dma_set(32'h200 + i, $urandom);
    end
    next_cycle();
    dma_we = 1'b0;
    @(negedge clk);
    check("noinv_valid", rsp_inv_valid, 0);
    check("noinv_addr", 32'(rsp_inv_addr), 0);
    check("noinv_error", error, 0);
    rsp_inv_ack = 1'b1;
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_write($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0, "rnd_wr");
      end else begin
        sz_pick = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31)
                                              : (1 << $urandom_range(0, 4)) - 1;
        do_read($urandom, 5'(sz_pick), $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                1'b1, -1, 0, 32'h0, $urandom_range(0, 1) == 1, "rnd_rd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
